// File: rtl/sd_frame_deserializer_if.sv
// rtl/sd_frame_deserializer_if.sv - control/data bundle between command controller and SD frame deserializer
interface sd_frame_deserializer_if #(
   parameter int MAX_BITS = 136,
   parameter int FS_W     = 8,
   parameter int TO_W     = 8
);
   logic                enable;
   logic                in;
   logic [FS_W-1:0]     framesize;
   logic [TO_W-1:0]     timeout;
   logic [MAX_BITS-1:0] out;
   logic                busy;
   logic                complete;
   logic                timeout_err;
   logic                crc_err;

   modport master (
      output enable, in, framesize, timeout,
      input  out, busy, complete, timeout_err, crc_err
   );

   modport slave (
      input  enable, in, framesize, timeout,
      output out, busy, complete, timeout_err, crc_err
   );
endinterface

// File: rtl/sd_frame_deserializer.sv
// rtl/sd_frame_deserializer.sv - SD CMD-line serial-to-parallel frame receiver with start-bit timeout
// Optional CRC7/end-bit check on 48-bit frames when SD_DES_CRC7_EN is defined.
module sd_frame_deserializer #(
   parameter int MAX_BITS = 136,
   parameter int FS_W     = 8,
   parameter int TO_W     = 8
) (
   input logic                    clk,
   input logic                    reset,
   sd_frame_deserializer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_START,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [MAX_BITS-1:0] r_out;
   logic [TO_W-1:0]     r_wait_cnt;
   logic [TO_W-1:0]     w_wait_cnt_inc;
   logic [FS_W-1:0]     r_bit_cnt;
   logic [FS_W-1:0]     w_bit_cnt_inc;
   logic [FS_W-1:0]     r_size;
   logic [FS_W-1:0]     w_size_clamped;
   logic                r_timeout_err;
   logic                w_timeout_hit;
   logic                w_crc_err;

   assign w_wait_cnt_inc = r_wait_cnt + TO_W'(1);
   assign w_bit_cnt_inc  = r_bit_cnt + FS_W'(1);
   assign w_timeout_hit  = (bus.timeout != '0) && (w_wait_cnt_inc == bus.timeout);

   always_comb begin
      w_size_clamped = bus.framesize;
      if (bus.framesize < FS_W'(2)) begin
         w_size_clamped = FS_W'(2);
      end else if (bus.framesize > FS_W'(MAX_BITS)) begin
         w_size_clamped = FS_W'(MAX_BITS);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Abort via enable low takes priority over start bit and timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.enable) w_next = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (!bus.enable)       w_next = S_IDLE;
            else if (!bus.in)      w_next = S_SHIFT;
            else if (w_timeout_hit) w_next = S_DONE;
         end
         S_SHIFT: begin
            if (!bus.enable)                  w_next = S_IDLE;
            else if (w_bit_cnt_inc == r_size) w_next = S_DONE;
         end
         S_DONE: begin
            if (!bus.enable) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out         <= '0;
         r_wait_cnt    <= '0;
         r_bit_cnt     <= '0;
         r_size        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_wait_cnt    <= '0;
               r_timeout_err <= 1'b0;
            end
            S_WAIT_START: begin
               if (bus.enable) begin
                  r_wait_cnt <= w_wait_cnt_inc;
                  if (!bus.in) begin
                     // Start bit lands in out[0]; clearing keeps bits above the frame at zero.
                     r_out     <= '0;
                     r_bit_cnt <= FS_W'(1);
                     r_size    <= w_size_clamped;
                  end else if (w_timeout_hit) begin
                     r_out         <= '0;
                     r_timeout_err <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               if (bus.enable) begin
                  r_out     <= {r_out[MAX_BITS-2:0], bus.in};
                  r_bit_cnt <= w_bit_cnt_inc;
               end
            end
            S_DONE: begin
               if (!bus.enable) r_timeout_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef SD_DES_CRC7_EN
   logic [6:0] r_crc;
   logic [6:0] w_crc_next;
   logic       r_crc_on;
   logic       w_crc_fb;

   assign w_crc_fb   = bus.in ^ r_crc[6];
   assign w_crc_next = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);

   // The start bit (frame bit 47) is zero, so the zero-initialised CRC is unchanged by it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_crc    <= '0;
         r_crc_on <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_crc_on <= 1'b0;
            end
            S_WAIT_START: begin
               if (bus.enable && !bus.in) begin
                  r_crc    <= '0;
                  r_crc_on <= (w_size_clamped == FS_W'(48));
               end else if (bus.enable && w_timeout_hit) begin
                  r_crc_on <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (bus.enable && (r_bit_cnt < FS_W'(40))) r_crc <= w_crc_next;
            end
            default: ;
         endcase
      end
   end

   assign w_crc_err = (r_state == S_DONE) && r_crc_on &&
                      ((r_crc != r_out[7:1]) || !r_out[0]);
`else
   assign w_crc_err = 1'b0;
`endif

   assign bus.out         = r_out;
   assign bus.busy        = (r_state == S_WAIT_START) || (r_state == S_SHIFT);
   assign bus.complete    = (r_state == S_DONE);
   assign bus.timeout_err = r_timeout_err;
   assign bus.crc_err     = w_crc_err;

endmodule

// File: doc/sd_frame_deserializer.md
# sd_frame_deserializer

Parametrised serial-to-parallel receiver for the SD host command line, successor to the fixed 136-bit command deserializer. Waits for a start bit, shifts in a runtime-selected number of bits MSB-first, and flags completion, start-bit timeout and, optionally, CRC7/end-bit errors. Sits between the CMD pad synchroniser and the command/response controller, which programs `framesize` and `timeout` per response type (48 or 136 bits).

## Interface
- `MAX_BITS`, 136: width of `out`; largest accepted frame.
- `FS_W`, 8: width of `framesize`; must satisfy 2^FS_W > MAX_BITS.
- `TO_W`, 8: width of `timeout` and the internal wait counter.

- `clk`  in  1  rising-edge clock; `in` is sampled on every edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arm receiver; deassertion aborts or acknowledges.
- `in`  in  1  serial CMD line, idle high.
- `framesize`  in  FS_W  frame length in bits, start bit included.
- `timeout`  in  TO_W  max cycles to wait for start bit; 0 = wait forever.
- `out`  out  MAX_BITS  received frame, last bit at `out[0]`.
- `busy`  out  1  high in WAIT_START or SHIFT.
- `complete`  out  1  high in DONE.
- `timeout_err`  out  1  DONE reached by timeout.
- `crc_err`  out  1  CRC7 or end-bit failure (see Configuration).

## Operation
- States: IDLE, WAIT_START, SHIFT, DONE. Reset: state IDLE, `out`=0, all flags 0.
- IDLE: `enable`=1 -> WAIT_START, wait counter cleared. Flags held 0.
- WAIT_START: counter +1 per edge. `in`=0 -> SHIFT; on that edge `out` <= {0..0, 1'b0}, bit count = 1, effective size latched = clamp(`framesize`, 2, MAX_BITS). Counter == `timeout` (nonzero) with `in`=1 -> DONE, `timeout_err`=1, `out`=0. Start bit wins if both on same edge.
- SHIFT: each edge `out` <= {out[MAX_BITS-2:0], in}, count +1. On edge where count reaches latched size -> DONE. Bits above size-1 remain 0.
- DONE: `complete`=1, `out` and error flags held stable; `enable`=0 -> IDLE (flags clear on that edge, `out` retained).
- `enable`=0 in WAIT_START or SHIFT: abort -> IDLE next edge; `complete` never asserts; `out` holds partial data.
- `framesize` changes after the start bit have no effect on the current frame.

## Timing
- Start bit sampled on edge E0; frame of N bits finishes on edge E(N-1); `out`, `complete`, `crc_err` valid immediately after E(N-1) (same registered update). No extra pipeline latency.
- Timeout: `timeout`=T fires on the T-th edge spent in WAIT_START.
- `busy` falls on the same edge `complete` rises.
- Asynchronous reset mid-frame: immediate return to reset values, no partial flag.
- `enable` held high in DONE: state held indefinitely; a new frame requires an `enable` low for at least one edge.

## Configuration
- `SD_DES_CRC7_EN` defined: when latched size == 48, CRC7 (x^7+x^3+1, zero init) runs over bits 47..8 as they arrive; in DONE `crc_err`=1 if computed CRC != `out[7:1]` or `out[0]`=0. Other sizes and timeouts: `crc_err`=0.
- Not defined: no CRC logic; `crc_err` tied 0.

## Test plan
- `framesize`=12, `in` high 3 cycles then 12'b010110011011 -> `out[11:0]`=12'b010110011011, upper bits 0, `complete` after 12th shift edge, `busy` 1 for exactly 12 edges.
- `timeout`=5, `in` held 1 -> `complete`=1, `timeout_err`=1, `out`=0 after 5th WAIT_START edge; `enable` low -> all flags 0 next edge.
- With `SD_DES_CRC7_EN`, `framesize`=48, stream 48'h400000000095 -> `crc_err`=0; stream 48'h400000000097 -> `crc_err`=1; without macro both -> 0.
- `framesize`=200 -> clamped to 136; frame completes after 136 bits, first received bit at `out[135]`.
- `enable` low after 5 shifted bits -> IDLE, `complete` stays 0, `out[4:0]` holds partial bits; re-enable receives next frame correctly.
- `reset` low mid-SHIFT -> `out`=0, `busy`=0, `complete`=0 immediately, without waiting for a clock edge.
